// File: rtl/axi_ethernet_0_rst_pkg.sv
// Shared definitions for the Ethernet soft-reset sequencer.
// Holds the sequencer state encoding and the default cycle constants.
`timescale 1ns/1ps
package axi_ethernet_0_rst_pkg;

   // Sequencer states. The encoding is fixed so the state can be shown in a status register.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ASSERT    = 2'd1,
      WAIT_LOCK = 2'd2,
      HOLDOFF   = 2'd3
   } rst_state_e;

   // Default timing: 100 MHz AXI-lite clock cycles.
   localparam int unsigned RST_CYCLES_DEF          = 16;
   localparam int unsigned LOCK_STABLE_CYCLES_DEF  = 64;
   localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 100000;
   localparam int unsigned HOLDOFF_CYCLES_DEF      = 32;
   localparam int unsigned CNT_W_DEF               = 16;

endpackage

// File: rtl/axi_ethernet_0_sync_2ff.sv
// Two-flop single-bit synchroniser with synchronous active-high clear.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high clear (both flops go to 0)
//   i_d   - asynchronous input bit
//   o_q   - synchronised output, two destination cycles behind i_d
`timescale 1ns/1ps
module axi_ethernet_0_sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Metastability chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/axi_ethernet_0_soft_rst_ctrl.sv
// Soft-reset sequencer feeding the Ethernet clocks/resets wrapper.
// Turns a software request or an MMCM lock loss into a fixed-width soft_rst
// pulse, waits for the lock to be stable again, then holds off new requests.
// Ports:
//   clk           - 100 MHz AXI-lite clock
//   reset         - synchronous active-high block reset
//   rst_req       - single-cycle software reset request
//   mmcm_locked_i - asynchronous MMCM lock status
//   err_clr       - single-cycle clear of the sticky timeout flag
//   soft_rst      - registered soft reset to the wrapper
//   busy          - registered, high whenever the sequencer is not IDLE
//   lock_timeout  - sticky flag, WAIT_LOCK ran out of time
//   rst_count     - saturating count of sequences started
`timescale 1ns/1ps
module axi_ethernet_0_soft_rst_ctrl
   import axi_ethernet_0_rst_pkg::*;
#(
   parameter int unsigned RST_CYCLES          = RST_CYCLES_DEF,
   parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
   parameter int unsigned HOLDOFF_CYCLES      = HOLDOFF_CYCLES_DEF,
   parameter int unsigned CNT_W               = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rst_req,
   input  logic             mmcm_locked_i,
   input  logic             err_clr,
   output logic             soft_rst,
   output logic             busy,
   output logic             lock_timeout,
   output logic [CNT_W-1:0] rst_count
);

   localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
   localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int unsigned HLD_W = $clog2(HOLDOFF_CYCLES + 1);

   rst_state_e r_state;
   rst_state_e w_next_state;

   logic [RST_W-1:0] r_rst_cnt,    w_rst_cnt_nxt;
   logic [STB_W-1:0] r_stable_cnt, w_stable_cnt_nxt;
   logic [TO_W-1:0]  r_to_cnt,     w_to_cnt_nxt;
   logic [HLD_W-1:0] r_hold_cnt,   w_hold_cnt_nxt;

   logic             r_locked_q;
   logic             r_soft_rst;
   logic             r_busy;
   logic             r_lock_timeout;
   logic [CNT_W-1:0] r_rst_count;

   logic w_locked_s;
   logic w_lock_fall;
   logic w_enter_assert;
   logic w_set_timeout;

   axi_ethernet_0_sync_2ff u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (mmcm_locked_i),
      .o_q   (w_locked_s)
   );

   // Falling edge of the synchronised lock against its previous value.
   assign w_lock_fall = r_locked_q & ~w_locked_s;

   // State register, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_rst_cnt      <= '0;
         r_stable_cnt   <= '0;
         r_to_cnt       <= '0;
         r_hold_cnt     <= '0;
         r_locked_q     <= 1'b0;
         r_soft_rst     <= 1'b0;
         r_busy         <= 1'b0;
         r_lock_timeout <= 1'b0;
         r_rst_count    <= '0;
      end else begin
         r_state      <= w_next_state;
         r_rst_cnt    <= w_rst_cnt_nxt;
         r_stable_cnt <= w_stable_cnt_nxt;
         r_to_cnt     <= w_to_cnt_nxt;
         r_hold_cnt   <= w_hold_cnt_nxt;
         r_locked_q   <= w_locked_s;
         // Outputs follow the next state so they line up with the state itself.
         r_soft_rst   <= (w_next_state == ASSERT);
         r_busy       <= (w_next_state != IDLE);
         // A new timeout takes priority over a clear in the same cycle.
         if (w_set_timeout) begin
            r_lock_timeout <= 1'b1;
         end else if (err_clr) begin
            r_lock_timeout <= 1'b0;
         end
         if (w_enter_assert && (r_rst_count != {CNT_W{1'b1}})) begin
            r_rst_count <= r_rst_count + CNT_W'(1);
         end
      end
   end

   // Next-state and counter logic.
   always_comb begin
      w_next_state     = r_state;
      w_rst_cnt_nxt    = r_rst_cnt;
      w_stable_cnt_nxt = r_stable_cnt;
      w_to_cnt_nxt     = r_to_cnt;
      w_hold_cnt_nxt   = r_hold_cnt;
      w_enter_assert   = 1'b0;
      w_set_timeout    = 1'b0;

      case (r_state)
         IDLE: begin
            // Coincident request and lock loss collapse into one entry.
            if (rst_req || w_lock_fall) begin
               w_next_state   = ASSERT;
               w_enter_assert = 1'b1;
            end
         end
         ASSERT: begin
            w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
            if (r_rst_cnt == RST_W'(RST_CYCLES - 1)) begin
               w_next_state = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            w_stable_cnt_nxt = w_locked_s ? (r_stable_cnt + STB_W'(1)) : '0;
            w_to_cnt_nxt     = r_to_cnt + TO_W'(1);
            // Stable lock is checked first so it wins over a same-cycle timeout.
            if (w_locked_s && (r_stable_cnt == STB_W'(LOCK_STABLE_CYCLES - 1))) begin
               w_next_state = HOLDOFF;
            end else if (r_to_cnt == TO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
               w_next_state  = IDLE;
               w_set_timeout = 1'b1;
            end
         end
         HOLDOFF: begin
            w_hold_cnt_nxt = r_hold_cnt + HLD_W'(1);
            if (r_hold_cnt == HLD_W'(HOLDOFF_CYCLES - 1)) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase

      // Every state starts with all counters at zero.
      if (w_next_state != r_state) begin
         w_rst_cnt_nxt    = '0;
         w_stable_cnt_nxt = '0;
         w_to_cnt_nxt     = '0;
         w_hold_cnt_nxt   = '0;
      end
   end

   assign soft_rst     = r_soft_rst;
   assign busy         = r_busy;
   assign lock_timeout = r_lock_timeout;
   assign rst_count    = r_rst_count;

endmodule
